// File: rtl/hdlc_peer_tx.sv
// Bit-serial HDLC frame transmitter: flags, zero-stuffed payload, CRC-16 FCS,
// abort on request or underrun. All bit activity is paced by i_bit_en.
module hdlc_peer_tx #(
    parameter int PRE_FLAGS = 1,
    parameter bit IDLE_FILL = 1'b1
) (
    input  logic       i_clk,
    input  logic       i_rst_n,
    input  logic       i_bit_en,
    input  logic [7:0] i_data,
    input  logic       i_valid,
    output logic       o_ready,
    input  logic       i_last,
    input  logic       i_abort_req,
    output logic       o_tx,
    output logic       o_active,
    output logic       o_done,
    output logic       o_aborted
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_OPEN_FLAG,
        S_DATA,
        S_FCS,
        S_CLOSE_FLAG,
        S_ABORT
    } state_t;

    localparam logic [7:0] FLAG      = 8'h7E;
    localparam logic [7:0] ABRT      = 8'h7F;
    localparam logic [1:0] LAST_FLAG = 2'(PRE_FLAGS - 1);

    state_t      r_state;
    logic [7:0]  r_hold;
    logic        r_hold_full;
    logic        r_hold_last;
    logic [7:0]  r_shift;
    logic        r_cur_last;
    logic [2:0]  r_bitcnt;
    logic [1:0]  r_flagcnt;
    logic [2:0]  r_ones;
    logic [15:0] r_crc;
    logic        r_fcs_hi;
    logic        r_fin;
    logic        r_tx;
    logic        r_active;
    logic        r_done;
    logic        r_aborted;

    logic        w_accept;
    logic        w_stuff;
    logic        w_byte_end;
    logic        w_data_bit;
    logic        w_fcs_bit;
    logic [15:0] w_crc_nxt;

    assign w_accept   = i_valid & ~r_hold_full;
    assign w_stuff    = (r_ones == 3'd5);
    assign w_byte_end = (r_bitcnt == 3'd7);
    assign w_data_bit = r_shift[0];
    assign w_fcs_bit  = r_crc[{r_fcs_hi, r_bitcnt}];
    assign w_crc_nxt  = {1'b0, r_crc[15:1]}
                      ^ ((r_crc[0] ^ w_data_bit) ? 16'hA001 : 16'h0000);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state     <= S_IDLE;
            r_hold      <= '0;
            r_hold_full <= 1'b0;
            r_hold_last <= 1'b0;
            r_shift     <= '0;
            r_cur_last  <= 1'b0;
            r_bitcnt    <= '0;
            r_flagcnt   <= '0;
            r_ones      <= '0;
            r_crc       <= '0;
            r_fcs_hi    <= 1'b0;
            r_fin       <= 1'b0;
            r_tx        <= IDLE_FILL;
            r_active    <= 1'b0;
            r_done      <= 1'b0;
            r_aborted   <= 1'b0;
        end else begin
            r_done    <= 1'b0;
            r_aborted <= 1'b0;
            if (w_accept) begin
                r_hold      <= i_data;
                r_hold_last <= i_last;
                r_hold_full <= 1'b1;
            end
            // A pending stuffed zero preempts whatever the state would send
            if (i_bit_en) begin
                if (w_stuff) begin
                    r_tx   <= 1'b0;
                    r_ones <= '0;
                end else begin
                    unique case (r_state)
                        S_IDLE: begin
                            r_tx <= IDLE_FILL;
                            if (r_hold_full) begin
                                r_tx      <= FLAG[0];
                                r_active  <= 1'b1;
                                r_bitcnt  <= 3'd1;
                                r_flagcnt <= '0;
                                r_state   <= S_OPEN_FLAG;
                            end
                        end
                        S_OPEN_FLAG: begin
                            r_tx     <= FLAG[r_bitcnt];
                            r_active <= 1'b1;
                            r_ones   <= '0;
                            r_bitcnt <= r_bitcnt + 3'd1;
                            if (w_byte_end) begin
                                if (i_abort_req) begin
                                    r_state <= S_ABORT;
                                end else if (r_flagcnt == LAST_FLAG) begin
                                    r_state     <= S_DATA;
                                    r_shift     <= r_hold;
                                    r_cur_last  <= r_hold_last;
                                    r_hold_full <= 1'b0;
                                    r_crc       <= '0;
                                end else begin
                                    r_flagcnt <= r_flagcnt + 2'd1;
                                end
                            end
                        end
                        S_DATA: begin
                            r_tx     <= w_data_bit;
                            r_crc    <= w_crc_nxt;
                            r_ones   <= w_data_bit ? r_ones + 3'd1 : 3'd0;
                            r_shift  <= {1'b0, r_shift[7:1]};
                            r_bitcnt <= r_bitcnt + 3'd1;
                            if (w_byte_end) begin
                                if (i_abort_req || (!r_cur_last && !r_hold_full)) begin
                                    r_state <= S_ABORT;
                                end else if (r_cur_last) begin
                                    r_state  <= S_FCS;
                                    r_fcs_hi <= 1'b0;
                                end else begin
                                    r_shift     <= r_hold;
                                    r_cur_last  <= r_hold_last;
                                    r_hold_full <= 1'b0;
                                end
                            end
                        end
                        S_FCS: begin
                            r_tx     <= w_fcs_bit;
                            r_ones   <= w_fcs_bit ? r_ones + 3'd1 : 3'd0;
                            r_bitcnt <= r_bitcnt + 3'd1;
                            if (w_byte_end) begin
                                if (i_abort_req) begin
                                    r_state <= S_ABORT;
                                end else if (!r_fcs_hi) begin
                                    r_fcs_hi <= 1'b1;
                                end else begin
                                    r_state <= S_CLOSE_FLAG;
                                end
                            end
                        end
                        S_CLOSE_FLAG: begin
                            if (r_fin) begin
                                r_fin     <= 1'b0;
                                r_tx      <= IDLE_FILL;
                                r_active  <= 1'b0;
                                r_done    <= 1'b1;
                                r_bitcnt  <= '0;
                                r_flagcnt <= '0;
                                r_state   <= r_hold_full ? S_OPEN_FLAG : S_IDLE;
                            end else begin
                                r_tx     <= FLAG[r_bitcnt];
                                r_ones   <= '0;
                                r_bitcnt <= r_bitcnt + 3'd1;
                                r_fin    <= w_byte_end;
                            end
                        end
                        S_ABORT: begin
                            if (r_fin) begin
                                r_fin       <= 1'b0;
                                r_tx        <= IDLE_FILL;
                                r_active    <= 1'b0;
                                r_aborted   <= 1'b1;
                                r_hold_full <= 1'b0;
                                r_bitcnt    <= '0;
                                r_state     <= S_IDLE;
                            end else begin
                                r_tx     <= ABRT[r_bitcnt];
                                r_ones   <= '0;
                                r_bitcnt <= r_bitcnt + 3'd1;
                                r_fin    <= w_byte_end;
                            end
                        end
                        default: r_state <= S_IDLE;
                    endcase
                end
            end
        end
    end

    assign o_ready   = ~r_hold_full;
    assign o_tx      = r_tx;
    assign o_active  = r_active;
    assign o_done    = r_done;
    assign o_aborted = r_aborted;

endmodule

// File: tb/tb_hdlc_peer_tx.sv
// Bench for hdlc_peer_tx: frames are planned as expected bit streams
// from the HDLC rules and compared bit by bit against the serial line.
module tb_hdlc_peer_tx;

    localparam int PF = 1;
    localparam bit IF = 1'b1;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       bit_en = 1'b0;
    logic [7:0] data = '0;
    logic       valid = 1'b0;
    logic       last = 1'b0;
    logic       abort_req = 1'b0;
    logic       ready, tx, active, done, aborted;

    int total = 0;
    int bad = 0;
    int mode = 0;
    bit be_q = 1'b0;

    bit         exp_q[$];
    int         len_q[$];
    bit         ev_q[$];
    bit         bq[$];
    logic [7:0] pay[$];
    int         st_ones;

    int bits_seen = 0;
    int fbits = 0;
    int cur_len = 0;
    int last_len = 0;
    int n_done = 0;
    int n_abort = 0;

    hdlc_peer_tx #(.PRE_FLAGS(PF), .IDLE_FILL(IF)) dut (
        .i_clk      (clk),
        .i_rst_n    (rst_n),
        .i_bit_en   (bit_en),
        .i_data     (data),
        .i_valid    (valid),
        .o_ready    (ready),
        .i_last     (last),
        .i_abort_req(abort_req),
        .o_tx       (tx),
        .o_active   (active),
        .o_done     (done),
        .o_aborted  (aborted)
    );

    initial forever #5 clk = ~clk;

    always @(posedge clk) be_q <= bit_en;

    initial begin : gen_be
        int cyc;
        cyc = 0;
        forever begin
            @(negedge clk);
            cyc++;
            case (mode)
                0: bit_en = 1'b1;
                1: bit_en = (cyc % 4 == 0);
                default: bit_en = 1'($urandom_range(0, 1));
            endcase
        end
    end

    initial begin : watchdog
        #800000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", nm, got, want);
        end
    endtask

    function automatic logic [15:0] crc_step(input logic [15:0] c, input bit b);
        return (c >> 1) ^ ((c[0] ^ b) ? 16'hA001 : 16'h0000);
    endfunction

    function automatic logic [15:0] crc_bytes(input int n);
        logic [15:0] c;
        c = '0;
        for (int i = 0; i < n; i++)
            for (int j = 0; j < 8; j++) c = crc_step(c, pay[i][j]);
        return c;
    endfunction

    function automatic void put_raw(input logic [7:0] v);
        for (int j = 0; j < 8; j++) bq.push_back(v[j]);
        st_ones = 0;
    endfunction

    function automatic void put_st(input bit b);
        bq.push_back(b);
        st_ones = b ? st_ones + 1 : 0;
        if (st_ones == 5) begin
            bq.push_back(1'b0);
            st_ones = 0;
        end
    endfunction

    // Expected line content of a frame sending nd bytes of pay
    function automatic void plan(input int nd, input bit abrt);
        logic [15:0] c;
        bq.delete();
        st_ones = 0;
        c = '0;
        for (int f = 0; f < PF; f++) put_raw(8'h7E);
        for (int i = 0; i < nd; i++)
            for (int j = 0; j < 8; j++) begin
                put_st(pay[i][j]);
                c = crc_step(c, pay[i][j]);
            end
        if (abrt) put_raw(8'h7F);
        else begin
            for (int j = 0; j < 16; j++) put_st(c[j]);
            put_raw(8'h7E);
        end
    endfunction

    function automatic void commit(input bit abrt);
        foreach (bq[i]) exp_q.push_back(bq[i]);
        len_q.push_back(bq.size());
        ev_q.push_back(abrt);
    endfunction

    function automatic logic [63:0] q2v();
        logic [63:0] v;
        v = '0;
        for (int i = 0; i < bq.size() && i < 64; i++) v[i] = bq[i];
        return v;
    endfunction

    task automatic push(input logic [7:0] b, input bit l);
        bit ok;
        ok = 1'b0;
        data = b;
        last = l;
        valid = 1'b1;
        for (int k = 0; k < 3000; k++) begin
            if (ready) begin
                @(posedge clk);
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
        @(negedge clk);
        valid = 1'b0;
        last = 1'b0;
        chk("accept", ok, 1);
    endtask

    task automatic wait_idle();
        for (int k = 0; k < 4000; k++) begin
            if (ev_q.size() == 0) break;
            @(negedge clk);
        end
        chk("frame_timeout", ev_q.size(), 0);
    endtask

    task automatic wait_bits(input int target);
        for (int k = 0; k < 4000; k++) begin
            if (bits_seen >= target) break;
            @(negedge clk);
        end
        chk("bit_wait", bits_seen >= target, 1);
    endtask

    initial begin : cmp
        bit prev_done, prev_ab, prev_tx, e;
        prev_done = 1'b0;
        prev_ab = 1'b0;
        prev_tx = 1'b1;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                exp_q.delete();
                len_q.delete();
                ev_q.delete();
                fbits = 0;
                cur_len = 0;
                prev_done = 1'b0;
                prev_ab = 1'b0;
                prev_tx = tx;
                continue;
            end
            if (done || aborted) begin
                if (done) n_done++;
                if (aborted) n_abort++;
                chk("pulse_width", {prev_done & done, prev_ab & aborted}, 0);
                chk("active_at_end", active, 0);
                if (ev_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_end: done=%0b aborted=%0b", done, aborted);
                end else begin
                    e = ev_q.pop_front();
                    chk("end_kind", {done, aborted}, e ? 2'b01 : 2'b10);
                    chk("frame_bits", fbits, len_q.pop_front());
                end
                fbits = 0;
            end
            prev_done = done;
            prev_ab = aborted;
            if (be_q) begin
                if (active) begin
                    if (exp_q.size() == 0) begin
                        total++;
                        bad++;
                        $display("FAIL extra_bit: tx=%0b with no bit expected", tx);
                    end else begin
                        chk("tx_bit", tx, exp_q.pop_front());
                        bits_seen++;
                        fbits++;
                    end
                end else begin
                    chk("idle_level", tx, IF);
                end
            end else begin
                chk("tx_hold", tx, prev_tx);
            end
            prev_tx = tx;
            if (active) cur_len++;
            else if (cur_len > 0) begin
                last_len = cur_len;
                cur_len = 0;
            end
        end
    end

    initial begin : main
        int base, len, n, maxrun, run, nd0;
        logic [15:0] c;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("rst_tx", tx, IF);
        chk("rst_ready", ready, 1);
        chk("rst_active", active, 0);
        chk("rst_done", done, 0);
        chk("rst_aborted", aborted, 0);

        pay = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39};
        chk("model_crc_check", crc_bytes(9), 16'hBB3D);
        pay = '{8'hFF};
        chk("model_crc_ff", crc_bytes(1), 16'h4040);

        pay = '{8'h00};
        plan(1, 0);
        chk("model_len_00", bq.size(), 40);
        chk("model_bits_00", q2v(), {8'h7E, 16'h0000, 8'h00, 8'h7E});
        commit(0);
        push(8'h00, 1);
        wait_idle();
        chk("frame00_len", last_len, 40);
        chk("frame00_done", n_done, 1);

        pay = '{8'hFF};
        plan(1, 0);
        chk("model_len_ff", bq.size(), 41);
        chk("model_bits_ff", q2v(), {8'h7E, 16'h4040, 9'h1DF, 8'h7E});
        commit(0);
        push(8'hFF, 1);
        wait_idle();

        mode = 1;
        pay = '{8'h7E, 8'h01, 8'hAA};
        plan(3, 0);
        len = bq.size();
        maxrun = 0;
        run = 0;
        for (int i = 8; i < len - 8; i++) begin
            run = bq[i] ? run + 1 : 0;
            if (run > maxrun) maxrun = run;
        end
        chk("model_max_run", maxrun, 5);
        c = crc_bytes(3);
        pay.push_back(c[7:0]);
        pay.push_back(c[15:8]);
        chk("model_rx_residue", crc_bytes(5), 16'h0000);
        commit(0);
        push(8'h7E, 0);
        push(8'h01, 0);
        push(8'hAA, 1);
        wait_idle();
        chk("slow_len", last_len, 4 * len);
        mode = 0;
        @(negedge clk);

        nd0 = n_done;
        pay = '{8'h11, 8'h22, 8'h33, 8'h44};
        plan(2, 1);
        commit(1);
        base = bits_seen;
        push(8'h11, 0);
        push(8'h22, 0);
        push(8'h33, 0);
        wait_bits(base + 18);
        abort_req = 1'b1;
        wait_idle();
        abort_req = 1'b0;
        @(negedge clk);
        chk("abort_ready", ready, 1);
        chk("abort_tx", tx, IF);
        chk("abort_active", active, 0);
        chk("abort_no_done", n_done, nd0);
        chk("abort_count", n_abort, 1);

        pay = '{8'h55};
        plan(1, 1);
        commit(1);
        push(8'h55, 0);
        wait_idle();
        chk("underrun_count", n_abort, 2);
        chk("underrun_ready", ready, 1);

        pay = '{8'h12, 8'h34};
        plan(2, 0);
        commit(0);
        base = bits_seen;
        nd0 = n_done;
        push(8'h12, 0);
        push(8'h34, 1);
        wait_bits(base + 28);
        #3 rst_n = 1'b0;
        #1;
        chk("midrst_tx", tx, IF);
        chk("midrst_ready", ready, 1);
        chk("midrst_active", active, 0);
        @(negedge clk);
        @(negedge clk);
        #2 rst_n = 1'b1;
        @(negedge clk);
        chk("midrst_no_done", n_done, nd0);
        pay = '{8'hA5, 8'h3C};
        plan(2, 0);
        commit(0);
        push(8'hA5, 0);
        push(8'h3C, 1);
        wait_idle();
        chk("postrst_done", n_done, nd0 + 1);

        for (int f = 0; f < 25; f++) begin
            mode = $urandom_range(0, 2);
            n = $urandom_range(1, 6);
            pay.delete();
            for (int i = 0; i < n; i++)
                pay.push_back(($urandom % 4 == 0) ? 8'hFF : 8'($urandom));
            plan(n, 0);
            commit(0);
            for (int i = 0; i < n; i++) begin
                push(pay[i], i == n - 1);
                repeat ($urandom_range(0, 2)) @(negedge clk);
            end
            if ($urandom % 2 == 0) wait_idle();
        end
        wait_idle();
        mode = 0;
        repeat (4) @(negedge clk);
        chk("final_ready", ready, 1);
        chk("final_active", active, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
